// File: rtl/sobel_filter.sv
// Streaming 3x3 Sobel gradient filter between two byte FIFOs.
// A 2*WIDTH+3 byte shift register supplies the window; one result every two cycles.
module sobel_filter #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 6
) (
  input  logic       clock,
  input  logic       reset,
  output logic       in_rd_en,
  input  logic       in_empty,
  input  logic [7:0] in_dout,
  output logic       out_wr_en,
  input  logic       out_full,
  output logic [7:0] out_din
);

  localparam int SR_LEN = 2 * WIDTH + 3;
  localparam int NPIX   = WIDTH * HEIGHT;
  localparam int PW     = $clog2(NPIX + 1);
  localparam int CW     = $clog2(WIDTH);
  localparam int RW     = $clog2(HEIGHT + 1);

  typedef enum logic [1:0] {
    PROLOGUE = 2'd0,
    FILTER   = 2'd1,
    OUTPUT   = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [7:0]      sr_r [SR_LEN];
  logic [PW-1:0]   pop_cnt_r, pop_cnt_s;
  logic [RW-1:0]   row_r, row_s;
  logic [CW-1:0]   col_r, col_s;
  logic [7:0]      result_r, result_s;
  logic            shift_s;
  logic [7:0]      shift_byte_s;
  logic            rd_s, wr_s;
  logic            need_pop_s;
  logic            border_s;
  logic signed [10:0] gx_s, gy_s;
  logic [7:0]      mag_s;

  function automatic logic signed [10:0] ext(input logic [7:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic [7:0] grad_mag(input logic signed [10:0] gx,
                                          input logic signed [10:0] gy);
    logic [10:0] ax;
    logic [10:0] ay;
    logic [11:0] sum;
    logic [10:0] half;
    ax   = gx[10] ? 11'(-gx) : 11'(gx);
    ay   = gy[10] ? 11'(-gy) : 11'(gy);
    sum  = {1'b0, ax} + {1'b0, ay};
    half = sum[11:1];
    return (half > 11'd255) ? 8'hFF : half[7:0];
  endfunction

  // Window p[r][c] = sr[r*WIDTH+c]; sums stay within 11 signed bits.
  always_comb begin
    gx_s = (ext(sr_r[2]) + (ext(sr_r[WIDTH + 2]) <<< 1) + ext(sr_r[2 * WIDTH + 2]))
         - (ext(sr_r[0]) + (ext(sr_r[WIDTH])     <<< 1) + ext(sr_r[2 * WIDTH]));
    gy_s = (ext(sr_r[2 * WIDTH]) + (ext(sr_r[2 * WIDTH + 1]) <<< 1) + ext(sr_r[2 * WIDTH + 2]))
         - (ext(sr_r[0]) + (ext(sr_r[1]) <<< 1) + ext(sr_r[2]));
    mag_s    = grad_mag(gx_s, gy_s);
    border_s = (row_r == RW'(0)) || (row_r == RW'(HEIGHT - 1)) ||
               (col_r == CW'(0)) || (col_r == CW'(WIDTH - 1));
  end

  // Next-state, FIFO handshakes and counter updates.
  always_comb begin
    state_s      = state_r;
    pop_cnt_s    = pop_cnt_r;
    row_s        = row_r;
    col_s        = col_r;
    result_s     = result_r;
    shift_s      = 1'b0;
    shift_byte_s = 8'h00;
    rd_s         = 1'b0;
    wr_s         = 1'b0;
    need_pop_s   = (pop_cnt_r < PW'(NPIX));
    case (state_r)
      PROLOGUE: begin
        if (!in_empty) begin
          rd_s         = 1'b1;
          shift_s      = 1'b1;
          shift_byte_s = in_dout;
          pop_cnt_s    = pop_cnt_r + PW'(1);
          if (pop_cnt_r == PW'(WIDTH + 1)) begin
            state_s = FILTER;
          end else begin
            state_s = PROLOGUE;
          end
        end else begin
          state_s = PROLOGUE;
        end
      end
      FILTER: begin
        if (!need_pop_s || !in_empty) begin
          // Past the last pop the window is flushed with zero bytes.
          if (need_pop_s) begin
            rd_s         = 1'b1;
            shift_byte_s = in_dout;
            pop_cnt_s    = pop_cnt_r + PW'(1);
          end else begin
            shift_byte_s = 8'h00;
          end
          shift_s  = 1'b1;
          result_s = border_s ? 8'h00 : mag_s;
          if (col_r == CW'(WIDTH - 1)) begin
            col_s = CW'(0);
            row_s = row_r + RW'(1);
          end else begin
            col_s = col_r + CW'(1);
          end
          state_s = OUTPUT;
        end else begin
          state_s = FILTER;
        end
      end
      OUTPUT: begin
        if (!out_full) begin
          wr_s = 1'b1;
          // row has already advanced past the last row once the final pixel is filtered
          if (row_r == RW'(HEIGHT)) begin
            state_s   = PROLOGUE;
            row_s     = RW'(0);
            col_s     = CW'(0);
            pop_cnt_s = PW'(0);
          end else begin
            state_s = FILTER;
          end
        end else begin
          state_s = OUTPUT;
        end
      end
      default: begin
        state_s = PROLOGUE;
      end
    endcase
  end

  assign in_rd_en  = rd_s & ~reset;
  assign out_wr_en = wr_s & ~reset;
  assign out_din   = result_r;

  // State, counters and result register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= PROLOGUE;
      pop_cnt_r <= '0;
      row_r     <= '0;
      col_r     <= '0;
      result_r  <= 8'h00;
    end else begin
      state_r   <= state_s;
      pop_cnt_r <= pop_cnt_s;
      row_r     <= row_s;
      col_r     <= col_s;
      result_r  <= result_s;
    end
  end

  // Line buffer: shifts toward index 0, new byte enters at the top.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SR_LEN; i++) begin
        sr_r[i] <= 8'h00;
      end
    end else if (shift_s) begin
      for (int i = 0; i < SR_LEN - 1; i++) begin
        sr_r[i] <= sr_r[i + 1];
      end
      sr_r[SR_LEN - 1] <= shift_byte_s;
    end
  end

endmodule

// File: tb/tb_sobel_filter.sv
// Scoreboard bench for sobel_filter: FIFO models feed frames, a monitor checks every write.
module tb_sobel_filter;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_rd_en, in_empty, out_wr_en, out_full;
  logic [7:0] in_dout, out_din;

  logic [7:0] in_q[$];
  logic [7:0] exp_q[$];
  int checks = 0, failures = 0;
  int pops = 0, writes = 0;
  bit rand_empty = 1'b0, stall_mode = 1'b0, ignore_out = 1'b0;

  sobel_filter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Upstream FIFO: drive on negedge, sample the pop request just before posedge.
  initial begin
    bit pend;
    pend = 1'b0;
    in_empty = 1'b1;
    in_dout = 8'h00;
    forever begin
      @(negedge clock);
      if (pend && in_q.size() > 0) begin
        void'(in_q.pop_front());
        pops++;
      end
      pend = 1'b0;
      if (in_q.size() == 0 || (rand_empty && $urandom_range(0, 2) == 0)) begin
        in_empty = 1'b1;
        in_dout = 8'h00;
      end else begin
        in_empty = 1'b0;
        in_dout = in_q[0];
      end
      #4;
      if (in_rd_en) begin
        check("rd_while_empty", int'(in_empty), 0);
        pend = !in_empty;
      end
    end
  end

  // Downstream FIFO + monitor: compares each write against the scoreboard.
  initial begin
    int stall;
    logic [7:0] e;
    stall = 0;
    out_full = 1'b0;
    forever begin
      @(negedge clock);
      if (stall > 0) begin
        out_full = 1'b1;
        stall--;
      end else begin
        out_full = 1'b0;
      end
      #4;
      if (out_wr_en) begin
        check("wr_while_full", int'(out_full), 0);
        writes++;
        if (!ignore_out) begin
          if (exp_q.size() == 0) begin
            check("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("pixel", int'(out_din), int'(e));
          end
        end
        if (stall_mode && (writes % 3 == 0)) stall = 5;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  // kind 0: constant 100, kind 1: ramp 10*col, kind 2: step 0/200 at col 4
  task automatic send_frame(input int kind);
    bit border;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        border = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
        case (kind)
          0: begin
            in_q.push_back(8'd100);
            exp_q.push_back(8'd0);
          end
          1: begin
            in_q.push_back(8'(10 * c));
            exp_q.push_back(border ? 8'd0 : 8'd40);
          end
          default: begin
            in_q.push_back(c < 4 ? 8'd0 : 8'd200);
            exp_q.push_back((!border && (c == 3 || c == 4)) ? 8'd255 : 8'd0);
          end
        endcase
      end
    end
  endtask

  task automatic drain(input string name, input int p0, input int w0, input int frames);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_q.size() != 0) && t < 5000) begin
      tick();
      t++;
    end
    repeat (12) tick();
    check({name, "_drained"}, exp_q.size(), 0);
    check({name, "_pops"}, pops - p0, N * frames);
    check({name, "_writes"}, writes - w0, N * frames);
  endtask

  initial begin
    int p0, w0, t;
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0, t;
    reset = 1'b1;
    in_q.push_back(8'd7);
    repeat (3) tick();
    check("reset_in_rd_en", int'(in_rd_en), 0);
    check("reset_out_wr_en", int'(out_wr_en), 0);
    check("reset_out_din", int'(out_din), 0);
    in_q.delete();
    reset = 1'b0;
    repeat (2) tick();

    p0 = pops; w0 = writes;
    send_frame(0);
    drain("const", p0, w0, 1);

    p0 = pops; w0 = writes;
    send_frame(1);
    drain("ramp", p0, w0, 1);

    p0 = pops; w0 = writes;
    send_frame(2);
    drain("step", p0, w0, 1);

    rand_empty = 1'b1;
    stall_mode = 1'b1;
    p0 = pops; w0 = writes;
    send_frame(1);
    drain("ramp_stall", p0, w0, 1);
    rand_empty = 1'b0;
    stall_mode = 1'b0;

    // Aborted frame: only 20 bytes arrive, then reset mid-frame.
    ignore_out = 1'b1;
    p0 = pops;
    for (int i = 0; i < 20; i++) in_q.push_back(8'(10 * (i % W)));
    t = 0;
    while (pops < p0 + 20 && t < 1000) begin
      tick();
      t++;
    end
    check("abort_pops", pops - p0, 20);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    check("midreset_in_rd_en", int'(in_rd_en), 0);
    check("midreset_out_wr_en", int'(out_wr_en), 0);
    check("midreset_out_din", int'(out_din), 0);
    in_q.delete();
    tick();
    reset = 1'b0;
    ignore_out = 1'b0;
    repeat (5) tick();
    p0 = pops; w0 = writes;
    send_frame(0);
    drain("after_reset", p0, w0, 1);

    p0 = pops; w0 = writes;
    send_frame(1);
    send_frame(1);
    drain("two_frames", p0, w0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sobel_filter.md
SOBEL_FILTER -- requirements
Module: sobel_filter

Interface
REQ-001 Parameter WIDTH, default REDUCED_WIDTH (globals): pixels per image row.
REQ-002 Parameter HEIGHT, default REDUCED_HEIGHT (globals): rows per image.
REQ-003 clock  in  1  single clock; all state on posedge.
REQ-004 reset  in  1  asynchronous, active-high; all state cleared on posedge reset.
REQ-005 in_rd_en  out  1  pops one blurred pixel from the upstream FIFO this cycle.
REQ-006 in_empty  in  1  upstream FIFO empty.
REQ-007 in_dout  in  8  blurred pixel, raster order, unsigned.
REQ-008 out_wr_en  out  1  pushes out_din to the downstream FIFO this cycle.
REQ-009 out_full  in  1  downstream FIFO full.
REQ-010 out_din  out  8  gradient magnitude, raster order, one per input pixel.

Function
REQ-011 The block SHALL hold a line buffer (shift register) of 2*WIDTH+3 bytes; each shift moves the contents one place toward index 0 and writes the new byte at index 2*WIDTH+2.
REQ-012 The 3x3 window SHALL be p[r][c] = sr[r*WIDTH+c] for r,c in 0..2; the centre pixel is sr[WIDTH+1].
REQ-013 States: PROLOGUE, FILTER, OUTPUT; reset state PROLOGUE.
REQ-014 PROLOGUE: in_rd_en = !in_empty; shift on each pop; after WIDTH+2 pops go to FILTER (pixel 0 then sits at centre).
REQ-015 FILTER, input phase: while the total pixels popped this frame < WIDTH*HEIGHT, proceed only when !in_empty; pop and shift. Otherwise no pop, and shift in 8'h00 unconditionally.
REQ-016 FILTER, on proceeding: compute from the pre-shift window, register the result, advance (row,col) (col wraps at WIDTH-1, row increments), go to OUTPUT.
REQ-017 Gx = (p02+2p12+p22)-(p00+2p10+p20); Gy = (p20+2p21+p22)-(p00+2p01+p02); signed, at least 11 bits, no overflow.
REQ-018 Magnitude = (|Gx|+|Gy|)>>1, saturated to 255.
REQ-019 Border pixels (row 0, row HEIGHT-1, col 0, col WIDTH-1) SHALL output 0 regardless of window contents.
REQ-020 OUTPUT: when !out_full, out_wr_en=1 with the registered result, then go to FILTER. When out_full, hold state and result; no shift, no pop.
REQ-021 After the write of pixel (HEIGHT-1, WIDTH-1), go to PROLOGUE and clear the row, col and pop counters. Line buffer contents are not cleared.
REQ-022 in_rd_en SHALL never be asserted in OUTPUT, nor when in_empty=1.
REQ-023 out_wr_en SHALL never be asserted outside OUTPUT, nor when out_full=1.
REQ-024 Throughput SHALL be one output per 2 cycles when unstalled; pixel k is written the cycle after its FILTER cycle.
REQ-025 Exactly WIDTH*HEIGHT pixels SHALL be popped and WIDTH*HEIGHT written per frame.

Reset
REQ-026 On reset:
  - state = PROLOGUE; line buffer, counters and result register = 0.
  - in_rd_en = 0, out_wr_en = 0, out_din = 0.
REQ-027 A reset asserted mid-frame SHALL abort the frame; the block restarts with the next popped byte treated as pixel (0,0).

Verification (WIDTH=8, HEIGHT=6, FIFOs never stalling unless stated)
REQ-028 Constant image, all pixels 100 -> 48 outputs, all 0.
REQ-029 Horizontal ramp, pixel = 10*col -> interior outputs 40; border outputs 0.
REQ-030 Vertical step, cols 0-3 = 0 and cols 4-7 = 200 -> interior cols 3 and 4 output 255 (saturated); interior cols 1-2 and 5-6 output 0.
REQ-031 Ramp image with out_full held high for 5 cycles on every 3rd write, and in_empty toggled randomly -> output stream identical to REQ-029; out_wr_en never asserted with out_full=1; in_rd_en never asserted with in_empty=1.
REQ-032 Reset pulsed after 20 pops, then a fresh constant-100 frame -> 48 zeros and no residual outputs from the aborted frame.
REQ-033 Two ramp frames back-to-back -> 96 outputs, both frames matching REQ-029; state returns to PROLOGUE between frames.
